// File: rtl/roi_pkg.sv
// Shared types and constants for the ROI coordinate path (box record, frame size, field widths).
package roi_pkg;

  localparam int HOR_W = 11;
  localparam int VER_W = 9;

  localparam int IMG_W_DEF = 1242;
  localparam int IMG_H_DEF = 375;

  typedef struct packed {
    logic [HOR_W-1:0] hmin;
    logic [HOR_W-1:0] hmax;
    logic [VER_W-1:0] vmin;
    logic [VER_W-1:0] vmax;
  } roi_box_t;

endpackage

// File: rtl/roi_fifo.sv
// First-word-fall-through FIFO of roi_box_t; head is always visible on dout while not empty.
module roi_fifo
  import roi_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  roi_box_t din,
  output logic     full,
  input  logic     pop,
  output roi_box_t dout,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  roi_box_t      mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as an all-zero box afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/roi_box_filter.sv
// Normalises projected boxes (swap, clamp, size/off-frame drop) and queues survivors for image_in_ROI.
// Define ROI_STATS_EN to add kept/dropped box counters with a synchronous clear.
//
// Handshake: a transfer happens on any rising edge where valid and ready are both high; the
// producer holds its box stable while valid is high and ready is low.
module roi_box_filter
  import roi_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int MIN_W = 8,
  parameter int MIN_H = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [HOR_W-1:0] HorMinIn,
  input  logic [HOR_W-1:0] HorMaxIn,
  input  logic [VER_W-1:0] VerMinIn,
  input  logic [VER_W-1:0] VerMaxIn,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [HOR_W-1:0] HorMinOut,
  output logic [HOR_W-1:0] HorMaxOut,
  output logic [VER_W-1:0] VerMinOut,
  output logic [VER_W-1:0] VerMaxOut
`ifdef ROI_STATS_EN
  ,
  output logic [15:0]      kept_cnt,
  output logic [15:0]      drop_cnt,
  input  logic             stats_clr
`endif
);

  localparam logic [HOR_W-1:0] H_LAST = HOR_W'(IMG_W - 1);
  localparam logic [VER_W-1:0] V_LAST = VER_W'(IMG_H - 1);

  logic [HOR_W-1:0] h_lo, h_hi, h_hi_c;
  logic [VER_W-1:0] v_lo, v_hi, v_hi_c;
  logic [HOR_W:0]   width;
  logic [VER_W:0]   height;
  logic             off_frame;
  logic             keep;
  logic             full, empty;
  logic             accept;
  roi_box_t         box_in, head;

  always_comb begin
    h_lo   = (HorMinIn > HorMaxIn) ? HorMaxIn : HorMinIn;
    h_hi   = (HorMinIn > HorMaxIn) ? HorMinIn : HorMaxIn;
    v_lo   = (VerMinIn > VerMaxIn) ? VerMaxIn : VerMinIn;
    v_hi   = (VerMinIn > VerMaxIn) ? VerMinIn : VerMaxIn;
    h_hi_c = (h_hi > H_LAST) ? H_LAST : h_hi;
    v_hi_c = (v_hi > V_LAST) ? V_LAST : v_hi;
    off_frame = (h_lo > H_LAST) || (v_lo > V_LAST);
    // Only meaningful when on-frame, where the clamped max can never fall below min.
    width  = {1'b0, h_hi_c} - {1'b0, h_lo} + 1'b1;
    height = {1'b0, v_hi_c} - {1'b0, v_lo} + 1'b1;
    keep   = !off_frame && (width >= (HOR_W+1)'(MIN_W)) && (height >= (VER_W+1)'(MIN_H));
    box_in = '{hmin: h_lo, hmax: h_hi_c, vmin: v_lo, vmax: v_hi_c};
  end

  assign ready_out = !full;
  assign accept    = valid_in && ready_out;
  assign valid_out = !empty;

  roi_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept && keep),
    .din   (box_in),
    .full  (full),
    .pop   (ready_in),
    .dout  (head),
    .empty (empty)
  );

  assign HorMinOut = head.hmin;
  assign HorMaxOut = head.hmax;
  assign VerMinOut = head.vmin;
  assign VerMaxOut = head.vmax;

`ifdef ROI_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kept_cnt <= '0;
      drop_cnt <= '0;
    end else if (stats_clr) begin
      kept_cnt <= '0;
      drop_cnt <= '0;
    end else if (accept) begin
      if (keep && kept_cnt != 16'hFFFF)       kept_cnt <= kept_cnt + 1'b1;
      else if (!keep && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_roi_box_filter.sv
// Directed bench for roi_box_filter: queue-based box model checked every cycle, plus literal pins.
module tb_roi_box_filter;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic        ready_out;
  logic [10:0] HorMinIn, HorMaxIn;
  logic [8:0]  VerMinIn, VerMaxIn;
  logic        valid_out;
  logic        ready_in;
  logic [10:0] HorMinOut, HorMaxOut;
  logic [8:0]  VerMinOut, VerMaxOut;
`ifdef ROI_STATS_EN
  logic [15:0] kept_cnt, drop_cnt;
  logic        stats_clr;
`endif

  int checks = 0;
  int errors = 0;
  logic [39:0] exp_q[$];

  roi_box_filter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .HorMinIn  (HorMinIn),
    .HorMaxIn  (HorMaxIn),
    .VerMinIn  (VerMinIn),
    .VerMaxIn  (VerMaxIn),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .HorMinOut (HorMinOut),
    .HorMaxOut (HorMaxOut),
    .VerMinOut (VerMinOut),
    .VerMaxOut (VerMaxOut)
`ifdef ROI_STATS_EN
    ,
    .kept_cnt  (kept_cnt),
    .drop_cnt  (drop_cnt),
    .stats_clr (stats_clr)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Box rules written as plain integer arithmetic on the raw corners.
  function automatic bit model_box(input int a, input int b, input int c, input int d,
                                   output logic [39:0] box);
    int hl, hh, vl, vh;
    hl = (a < b) ? a : b;  hh = (a < b) ? b : a;
    vl = (c < d) ? c : d;  vh = (c < d) ? d : c;
    box = '0;
    if (hl > 1241 || vl > 374) return 0;
    if (hh > 1241) hh = 1241;
    if (vh > 374)  vh = 374;
    if (hh - hl + 1 < 8 || vh - vl + 1 < 8) return 0;
    box = {11'(hl), 11'(hh), 9'(vl), 9'(vh)};
    return 1;
  endfunction

  // Model: tracks what the queue must hold, using its own occupancy for both handshakes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_q.delete();
    else begin
      bit do_acc, do_pop, kp;
      logic [39:0] b;
      do_acc = valid_in && (exp_q.size() < DEPTH);
      do_pop = ready_in && (exp_q.size() != 0);
      kp = model_box(int'(HorMinIn), int'(HorMaxIn), int'(VerMinIn), int'(VerMaxIn), b);
      if (do_pop) void'(exp_q.pop_front());
      if (do_acc && kp) exp_q.push_back(b);
    end
  end

  // scoreboard compare, every falling edge out of reset
  always @(negedge clk) begin
    if (rst_n) begin
      check("valid_out", valid_out, (exp_q.size() != 0));
      check("ready_out", ready_out, (exp_q.size() < DEPTH));
      if (exp_q.size() != 0)
        check("head_box", {HorMinOut, HorMaxOut, VerMinOut, VerMaxOut}, exp_q[0]);
    end
  end

  // driver: present a box from a falling edge and hold it until accepted
  task automatic send(input int hmin, input int hmax, input int vmin, input int vmax);
    bit ok;
    ok = 0;
    valid_in = 1'b1;
    HorMinIn = 11'(hmin); HorMaxIn = 11'(hmax);
    VerMinIn = 9'(vmin);  VerMaxIn = 9'(vmax);
    for (int n = 0; n < 100 && !ok; n++) begin
      ok = ready_out;
      @(posedge clk);
      if (!ok) @(negedge clk);
    end
    if (!ok) check("send_timeout", 1'b0, 1'b1);
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && valid_out; n++) @(negedge clk);
    check("drain_empty", valid_out, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
    HorMinIn = '0; HorMaxIn = '0; VerMinIn = '0; VerMaxIn = '0;
`ifdef ROI_STATS_EN
    stats_clr = 1'b0;
`endif
    #12;
    check("rst_valid_out", valid_out, 1'b0);
    check("rst_coords", {HorMinOut, HorMaxOut, VerMinOut, VerMaxOut}, 40'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready_out", ready_out, 1'b1);
    @(negedge clk);

    send(100, 300, 50, 200);
    check("normal_valid", valid_out, 1'b1);
    check("normal_box", {HorMinOut, HorMaxOut, VerMinOut, VerMaxOut},
          {11'd100, 11'd300, 9'd50, 9'd200});
`ifdef ROI_STATS_EN
    check("normal_kept_cnt", kept_cnt, 40'd1);
`endif

    send(400, 350, 10, 60);
    check("swap_box", {HorMinOut, HorMaxOut, VerMinOut, VerMaxOut},
          {11'd350, 11'd400, 9'd10, 9'd60});

    send(1200, 1500, 300, 450);
    check("clamp_box", {HorMinOut, HorMaxOut, VerMinOut, VerMaxOut},
          {11'd1200, 11'd1241, 9'd300, 9'd374});

    send(1300, 1400, 10, 60);
    check("drop_offframe", valid_out, 1'b0);
    send(10, 14, 10, 60);
    check("drop_narrow", valid_out, 1'b0);
    send(1238, 2000, 10, 60);
    check("drop_clamped_narrow", valid_out, 1'b0);
`ifdef ROI_STATS_EN
    check("drop_cnt3", drop_cnt, 40'd3);
`endif

    // backpressure: fill the queue, then the fifth box waits for the first pop
    ready_in = 1'b0;
    for (int i = 1; i <= 4; i++) send(i * 20, i * 20 + 50, i * 10, i * 10 + 30);
    check("full_ready_low", ready_out, 1'b0);
    check("full_head", {HorMinOut, HorMaxOut, VerMinOut, VerMaxOut},
          {11'd20, 11'd70, 9'd10, 9'd40});
    valid_in = 1'b1;
    HorMinIn = 11'd100; HorMaxIn = 11'd150; VerMinIn = 9'd50; VerMaxIn = 9'd80;
    @(negedge clk);
    check("full_hold", ready_out, 1'b0);
    ready_in = 1'b1;
    @(negedge clk);
    check("ready_after_pop", ready_out, 1'b1);
    check("second_head", {HorMinOut, HorMaxOut, VerMinOut, VerMaxOut},
          {11'd40, 11'd90, 9'd20, 9'd50});
    @(negedge clk);
    valid_in = 1'b0;
    drain();
`ifdef ROI_STATS_EN
    check("kept_cnt8", kept_cnt, 40'd8);
    stats_clr = 1'b1;
    send(1300, 1400, 10, 60);
    stats_clr = 1'b0;
    check("clr_drop_cnt", drop_cnt, 40'd0);
    check("clr_kept_cnt", kept_cnt, 40'd0);
    send(1300, 1400, 10, 60);
    check("drop_after_clr", drop_cnt, 40'd1);
`endif

    // reset with three boxes queued
    ready_in = 1'b0;
    send(500, 600, 100, 150);
    send(510, 610, 110, 160);
    send(520, 620, 120, 170);
    check("queued3_valid", valid_out, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", valid_out, 1'b0);
    check("async_rst_coords", {HorMinOut, HorMaxOut, VerMinOut, VerMaxOut}, 40'd0);
`ifdef ROI_STATS_EN
    check("async_rst_kept", kept_cnt, 40'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    ready_in = 1'b1;
    #1;
    check("post_rst_ready", ready_out, 1'b1);
    check("post_rst_valid", valid_out, 1'b0);
    @(negedge clk);

    send(0, 1241, 0, 374);
    check("full_frame_box", {HorMinOut, HorMaxOut, VerMinOut, VerMaxOut},
          {11'd0, 11'd1241, 9'd0, 9'd374});
    send(0, 7, 0, 7);
    check("min_size_box", {HorMinOut, HorMaxOut, VerMinOut, VerMaxOut},
          {11'd0, 11'd7, 9'd0, 9'd7});
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/roi_box_filter.md
# roi_box_filter

Sits between project2image and image_in_ROI on the ROI coordinate path. Normalises each projected bounding box: swaps inverted corners, clamps to the camera frame, and drops boxes that are off-frame or too small. Surviving boxes are buffered in a small FIFO, so project2image can issue several boxes while image_in_ROI is still fetching a previous one from the ARM side.

## Interface
- IMG_W, 1242: frame width in pixels; valid columns 0..IMG_W-1.
- IMG_H, 375: frame height in pixels; valid rows 0..IMG_H-1.
- MIN_W, 8: minimum clamped box width (HorMax-HorMin+1) kept.
- MIN_H, 8: minimum clamped box height kept.
- DEPTH, 4: FIFO entries, power of two, at least 2.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  a box is presented by project2image.
- ready_out  out  1  block accepts the box this cycle.
- HorMinIn, HorMaxIn  in  11  unsigned column corners.
- VerMinIn, VerMaxIn  in  9  unsigned row corners.
- valid_out  out  1  head box is valid.
- ready_in  in  1  image_in_ROI accepts the head box.
- HorMinOut, HorMaxOut  out  11  normalised columns.
- VerMinOut, VerMaxOut  out  9  normalised rows.

## Operation
- Accept happens when valid_in && ready_out. ready_out = !full.
- Normalisation is combinational on the input and completes within the accept cycle.
  - Swap: if HorMinIn > HorMaxIn, swap the pair. Apply the same rule independently to the Ver pair.
  - Off-frame: if min > IMG_W-1 (Hor) or min > IMG_H-1 (Ver), drop the box.
  - Clamp: max = min(max, IMG_W-1) and max = min(max, IMG_H-1). Min needs no lower clamp (unsigned).
  - Size: compute width = max-min+1 at 12 bits and height at 10 bits. Drop if width < MIN_W or height < MIN_H.
- A dropped box is still accepted (handshake completes) but is not written to the FIFO.
- A kept box is written to the FIFO tail. The FIFO entry is 40 bits: {HorMin, HorMax, VerMin, VerMax}.
- valid_out = !empty. Outputs always show the FIFO head. Pop on valid_out && ready_in.
- Output fields hold steady while valid_out && !ready_in.

## Timing
- Reset values:
  - FIFO pointers and count are 0.
  - valid_out = 0 and ready_out = 1 (once reset is released).
  - All coordinate outputs are 0.
  - Stats counters are 0.
- Latency: a box kept at accept edge N is visible on valid_out and the outputs after edge N (same-cycle head if FIFO was empty).
- Full: ready_out = 0, and it stays 0 in a cycle where a pop occurs (no write-through on full). It rises the cycle after the pop.
- Empty with a simultaneous write: valid_out rises after that edge. There is no combinational input-to-output path.
- Simultaneous push and pop when neither full nor empty: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits.
- Reset asserted mid-operation: FIFO contents are discarded immediately. valid_out falls asynchronously.

## Configuration
- ROI_STATS_EN defined adds three outputs:
  - kept_cnt  out  16: saturating count of kept boxes.
  - drop_cnt  out  16: saturating count of dropped boxes.
  - stats_clr  in  1: synchronous clear of both counters; clear has priority over increment.
- ROI_STATS_EN undefined: these ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- Shared package roi_pkg holds:
  - typedef roi_box_t (packed hmin[10:0], hmax[10:0], vmin[8:0], vmax[8:0]);
  - constants IMG_W_DEF=1242 and IMG_H_DEF=375;
  - HOR_W=11 and VER_W=9.
- Sub-module roi_fifo: generic synchronous FIFO of roi_box_t with DEPTH. It provides full/empty, first-word-fall-through output, and asynchronous active-low reset.
- The top level holds normalisation logic, the handshake and the optional stats.

## Test plan
- Normal box Hor 100..300, Ver 50..200 with ready_in=1 -> output 100/300/50/200 one edge after accept; kept_cnt=1.
- Inverted box HorMin=400, HorMax=350, Ver 10..60 -> output Hor 350..400, Ver 10..60.
- Clamp: Hor 1200..1500, Ver 300..450 -> output Hor 1200..1241, Ver 300..374.
- Drops:
  - HorMin=1300 (off-frame) -> accepted, no valid_out, drop_cnt+1.
  - Hor 10..14 (width 5) -> dropped.
  - Hor 1238..2000 (clamped width 4) -> dropped.
- Backpressure: ready_in=0, push 5 valid boxes -> ready_out=0 after the 4th. Release ready_in -> boxes emerge in order; ready_out=1 one cycle after the first pop; the 5th box is then accepted.
- Reset: assert rst_n=0 with 3 boxes queued -> valid_out=0 immediately. After release, the FIFO is empty and ready_out=1.
